// File: rtl/gpu_core_pkg.sv
// Shared opcode, instruction-field and sequencer-state definitions for the
// GPU scalar core.
package gpu_core_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_MUL   = 4'h3;
  localparam logic [3:0] OP_DIV   = 4'h4;
  localparam logic [3:0] OP_CMPGE = 4'h5;
  localparam logic [3:0] OP_SHR   = 4'h6;
  localparam logic [3:0] OP_SHL   = 4'h7;
  localparam logic [3:0] OP_AND   = 4'h8;
  localparam logic [3:0] OP_OR    = 4'h9;
  localparam logic [3:0] OP_XOR   = 4'hA;
  localparam logic [3:0] OP_LD    = 4'hB;
  localparam logic [3:0] OP_LDI   = 4'hC;
  localparam logic [3:0] OP_ST    = 4'hD;
  localparam logic [3:0] OP_BR    = 4'hE;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam int unsigned OP_MSB  = 15;
  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned RA_MSB  = 11;
  localparam int unsigned RA_LSB  = 8;
  localparam int unsigned RB_MSB  = 7;
  localparam int unsigned RB_LSB  = 4;
  localparam int unsigned RD_MSB  = 3;
  localparam int unsigned RD_LSB  = 0;
  localparam int unsigned IMM_SEL = 11;
  localparam int unsigned IMM_MSB = 10;
  localparam int unsigned IMM_LSB = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_DONE
  } state_t;

  // Opcodes 1..C (ALU, ld, immediate/core-id) are the only ones writing RF[rd].
  function automatic logic writes_rf(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_LDI);
  endfunction

endpackage

// File: rtl/gpu_core_param_if.sv
// Shared-memory req/ack port between a GPU core (master) and the interconnect.
interface gpu_core_param_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 12
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_ack, mem_rdata);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_ack, mem_rdata);
endinterface

// File: rtl/gpu_alu.sv
// Combinational ALU of the GPU scalar core; all results wrap to DATA_W bits.
module gpu_alu
  import gpu_core_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);
  always_comb begin
    result = '0;
    case (op)
      OP_ADD:   result = a + b;
      OP_SUB:   result = a - b;
      OP_MUL:   result = a * b;
      OP_DIV:   result = (b == '0) ? '1 : a / b;
      OP_CMPGE: result = DATA_W'(a >= b);
      OP_SHR:   result = a >> b[3:0];
      OP_SHL:   result = a << b[3:0];
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
      default:  result = '0;
    endcase
  end
endmodule

// File: rtl/gpu_core_param.sv
// Parametrised GPU scalar core: program memory, 16-entry register file and a
// FETCH/DECODE/EXEC/MEM/WB sequencer driving a req/ack shared-memory port.
module gpu_core_param
  import gpu_core_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned IMEM_DEPTH = 16,
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned NUM_CORES  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [$clog2(NUM_CORES)-1:0] core_id,
  input  logic                         prog_valid,
  output logic                         prog_ready,
  input  logic [15:0]                  prog_data,
  input  logic                         mask_valid,
  input  logic [NUM_CORES-1:0]         mask_data,
  input  logic                         abort,
  output logic                         done,
  output logic                         busy,
  gpu_core_param_if.master             mem
);
  localparam int unsigned PC_W = $clog2(IMEM_DEPTH);

  state_t            state, state_nx;
  logic [15:0]       imem [IMEM_DEPTH];
  logic [DATA_W-1:0] rf [16];
  logic [PC_W-1:0]   pc, wptr;
  logic              active;
  logic [15:0]       ir;
  logic [DATA_W-1:0] op_a, op_b, op_d, res;
  logic [DATA_W-1:0] alu_res, exec_res;
  logic [3:0]        op;
  logic              load_fire, last_word, act_eff, is_mem, taken, at_end;

  assign op        = ir[OP_MSB:OP_LSB];
  assign load_fire = prog_valid && prog_ready && (state == S_IDLE);
  assign last_word = load_fire && (wptr == PC_W'(IMEM_DEPTH - 1));
  // A mask strobe in the same cycle as the last program word already counts.
  assign act_eff   = mask_valid ? mask_data[core_id] : active;
  assign is_mem    = (op == OP_LD) || (op == OP_ST);
  assign taken     = (op == OP_BR) && (op_a != '0);
  assign at_end    = (op == OP_HALT) || (!taken && (pc == PC_W'(IMEM_DEPTH - 1)));

  gpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op),
    .a      (op_a),
    .b      (op_b),
    .result (alu_res)
  );

  always_comb begin
    exec_res = alu_res;
    if (op == OP_LDI)
      exec_res = ir[IMM_SEL] ? DATA_W'(ir[IMM_MSB:IMM_LSB]) : DATA_W'(core_id);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (abort && (state != S_IDLE)) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (last_word) state_nx = act_eff ? S_FETCH : S_DONE;
        S_FETCH:  state_nx = S_DECODE;
        S_DECODE: state_nx = S_EXEC;
        S_EXEC:   state_nx = is_mem ? S_MEM : S_WB;
        S_MEM:    if (mem.mem_ack) state_nx = S_WB;
        S_WB:     state_nx = at_end ? S_DONE : S_FETCH;
        S_DONE:   state_nx = S_IDLE;
        default:  state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && load_fire) imem[wptr] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc            <= '0;
      wptr          <= '0;
      active        <= 1'b1;
      ir            <= '0;
      op_a          <= '0;
      op_b          <= '0;
      op_d          <= '0;
      res           <= '0;
      prog_ready    <= 1'b0;
      done          <= 1'b0;
      busy          <= 1'b0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      for (int unsigned i = 0; i < 16; i++) rf[i] <= '0;
    end else begin
      // Status outputs are registered copies of the state being entered.
      prog_ready <= (state_nx == S_IDLE);
      done       <= (state_nx == S_DONE);
      busy       <= (state_nx inside {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB});
      if (abort && (state != S_IDLE)) begin
        wptr        <= '0;
        mem.mem_req <= 1'b0;
        mem.mem_we  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (mask_valid) active <= mask_data[core_id];
            if (load_fire) wptr <= wptr + PC_W'(1);
            if (last_word) begin
              wptr <= '0;
              pc   <= '0;
            end
          end
          S_FETCH:  ir <= imem[pc];
          S_DECODE: begin
            op_a <= rf[ir[RA_MSB:RA_LSB]];
            op_b <= rf[ir[RB_MSB:RB_LSB]];
            op_d <= rf[ir[RD_MSB:RD_LSB]];
          end
          S_EXEC: begin
            res <= exec_res;
            if (is_mem) begin
              mem.mem_req   <= 1'b1;
              mem.mem_we    <= (op == OP_ST);
              mem.mem_addr  <= ADDR_W'({op_b, op_a});
              mem.mem_wdata <= op_d;
            end
          end
          S_MEM: begin
            if (mem.mem_ack) begin
              mem.mem_req <= 1'b0;
              mem.mem_we  <= 1'b0;
              if (op == OP_LD) res <= mem.mem_rdata;
            end
          end
          S_WB: begin
            if (writes_rf(op)) rf[ir[RD_MSB:RD_LSB]] <= res;
            if (!at_end) pc <= taken ? ir[PC_W-1:0] : pc + PC_W'(1);
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_gpu_core_param.sv
// Directed self-checking bench for gpu_core_param (default parameters, lane 5).
module tb_gpu_core_param;
  import gpu_core_pkg::*;

  logic        clk = 1'b0;
  logic        reset, prog_valid, prog_ready, mask_valid, abort, done, busy;
  logic [3:0]  core_id;
  logic [15:0] prog_data;
  logic [15:0] mask_data;
  logic [15:0] prog [16];
  int          n_pass = 0, n_total = 0;
  int          cyc, held;
  logic        seen;

  gpu_core_param_if #(.DATA_W(8), .ADDR_W(12)) bus ();

  gpu_core_param #(.DATA_W(8), .IMEM_DEPTH(16), .ADDR_W(12), .NUM_CORES(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .core_id    (core_id),
    .prog_valid (prog_valid),
    .prog_ready (prog_ready),
    .prog_data  (prog_data),
    .mask_valid (mask_valid),
    .mask_data  (mask_data),
    .abort      (abort),
    .done       (done),
    .busy       (busy),
    .mem        (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ins(input logic [3:0] o, input logic [3:0] a,
                                      input logic [3:0] b, input logic [3:0] d);
    return {o, a, b, d};
  endfunction

  function automatic logic [15:0] ldi(input logic [3:0] d, input logic [6:0] imm);
    return {4'hC, 1'b1, imm, d};
  endfunction

  task automatic load_prog();
    for (int i = 0; i < 16; i++) begin
      prog_valid = 1'b1;
      prog_data  = prog[i];
      tick();
    end
    prog_valid = 1'b0;
    prog_data  = '0;
  endtask

  task automatic wait_done(input int max, output int c);
    c = 0;
    while (done !== 1'b1 && c < max) begin tick(); c++; end
  endtask

  task automatic wait_req(input int max, output int c);
    c = 0;
    while (bus.mem_req !== 1'b1 && c < max) begin tick(); c++; end
  endtask

  task automatic serve(input int delay, input logic [7:0] rd, output int h);
    h = 1;
    repeat (delay) begin tick(); if (bus.mem_req) h++; end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = rd;
    tick();
    bus.mem_ack   = 1'b0;
  endtask

  task automatic mem_program();
    foreach (prog[i]) prog[i] = '0;
    prog[0] = ldi(4'd1, 7'h23);
    prog[1] = ldi(4'd2, 7'h01);
    prog[2] = ldi(4'd4, 7'd100);
    prog[3] = ldi(4'd7, 7'd65);
    prog[4] = ins(OP_ADD, 4'd4, 4'd7, 4'd4);
    prog[5] = ins(OP_ST, 4'd1, 4'd2, 4'd4);
    prog[6] = ins(OP_LD, 4'd1, 4'd2, 4'd5);
    prog[7] = 16'hF000;
  endtask

  initial begin
    reset = 1'b1; prog_valid = 1'b0; prog_data = '0; mask_valid = 1'b0;
    mask_data = '0; abort = 1'b0; core_id = 4'd5;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    tick(); tick();
    chk("rst_prog_ready", prog_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req", bus.mem_req, 0);
    chk("rst_we", bus.mem_we, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    chk("rst_pc", dut.pc, 0);
    chk("rst_active", dut.active, 1);
    reset = 1'b0;
    tick();
    chk("ready_after_rst", prog_ready, 1);

    // Basic: 5 + 3
    foreach (prog[i]) prog[i] = '0;
    prog[0] = ldi(4'd1, 7'd5);
    prog[1] = ldi(4'd2, 7'd3);
    prog[2] = ins(OP_ADD, 4'd1, 4'd2, 4'd3);
    prog[3] = 16'hF000;
    load_prog();
    chk("t1_busy", busy, 1);
    wait_done(100, cyc);
    chk("t1_latency", cyc, 16);
    chk("t1_r3", dut.rf[3], 8'd8);
    tick();
    chk("t1_done_pulse", done, 0);
    chk("t1_ready_back", prog_ready, 1);

    // Arithmetic corners, runs off the last program word
    prog[0]  = ldi(4'd1, 7'd100);
    prog[1]  = ins(OP_ADD, 4'd1, 4'd1, 4'd2);
    prog[2]  = ins(OP_ADD, 4'd2, 4'd1, 4'd3);
    prog[3]  = ldi(4'd4, 7'd7);
    prog[4]  = ldi(4'd5, 7'd0);
    prog[5]  = ins(OP_DIV, 4'd4, 4'd5, 4'd6);
    prog[6]  = ldi(4'd7, 7'd3);
    prog[7]  = ldi(4'd8, 7'd5);
    prog[8]  = ins(OP_SUB, 4'd7, 4'd8, 4'd9);
    prog[9]  = ldi(4'd10, 7'd64);
    prog[10] = ldi(4'd11, 7'd65);
    prog[11] = ins(OP_ADD, 4'd10, 4'd11, 4'd10);
    prog[12] = ldi(4'd12, 7'd1);
    prog[13] = ins(OP_SHL, 4'd10, 4'd12, 4'd13);
    prog[14] = ins(OP_CMPGE, 4'd4, 4'd8, 4'd14);
    prog[15] = ins(OP_MUL, 4'd1, 4'd8, 4'd15);
    load_prog();
    wait_done(200, cyc);
    chk("ar_latency", cyc, 64);
    chk("ar_add_wrap", dut.rf[3], 8'h2C);
    chk("ar_div0", dut.rf[6], 8'hFF);
    chk("ar_sub_wrap", dut.rf[9], 8'hFE);
    chk("ar_shl", dut.rf[13], 8'h02);
    chk("ar_cmpge", dut.rf[14], 8'h01);
    chk("ar_mul", dut.rf[15], 8'hF4);
    tick();

    // Store then load through the memory port
    mem_program();
    load_prog();
    wait_req(100, cyc);
    chk("st_req_latency", cyc, 23);
    chk("st_we", bus.mem_we, 1);
    chk("st_addr", bus.mem_addr, 12'h123);
    chk("st_wdata", bus.mem_wdata, 8'hA5);
    serve(3, 8'h00, held);
    chk("st_req_held", held, 4);
    chk("st_req_drop", bus.mem_req, 0);
    wait_req(100, cyc);
    chk("ld_req_latency", cyc, 4);
    chk("ld_we", bus.mem_we, 0);
    chk("ld_addr", bus.mem_addr, 12'h123);
    serve(0, 8'hA5, held);
    chk("ld_req_drop", bus.mem_req, 0);
    wait_done(100, cyc);
    chk("ld_halt_latency", cyc, 5);
    chk("ld_r5", dut.rf[5], 8'hA5);
    tick();

    // Countdown loop
    foreach (prog[i]) prog[i] = '0;
    prog[0] = ldi(4'd1, 7'd3);
    prog[1] = ldi(4'd6, 7'd1);
    prog[2] = ldi(4'd2, 7'd0);
    prog[3] = ins(OP_SUB, 4'd1, 4'd6, 4'd1);
    prog[4] = ins(OP_ADD, 4'd2, 4'd6, 4'd2);
    prog[5] = {OP_BR, 4'd1, 8'd3};
    prog[6] = ins(OP_LDI, 4'd0, 4'd0, 4'd7);
    prog[7] = 16'hF000;
    load_prog();
    wait_done(300, cyc);
    chk("lp_latency", cyc, 56);
    chk("lp_iterations", dut.rf[2], 8'd3);
    chk("lp_r1", dut.rf[1], 8'd0);
    chk("lp_core_id", dut.rf[7], 8'd5);
    tick();

    // Inactive lane
    mask_valid = 1'b1;
    mask_data  = 16'hFFDF;
    tick();
    mask_valid = 1'b0;
    chk("mask_active", dut.active, 0);
    mem_program();
    load_prog();
    chk("mask_done", done, 1);
    chk("mask_busy", busy, 0);
    seen = 1'b0;
    repeat (4) begin tick(); if (bus.mem_req || done) seen = 1'b1; end
    chk("mask_quiet", seen, 0);
    chk("mask_ready", prog_ready, 1);
    mask_valid = 1'b1;
    mask_data  = '1;
    tick();
    mask_valid = 1'b0;
    chk("mask_restore", dut.active, 1);

    // Reset while in MEM
    load_prog();
    wait_req(100, cyc);
    chk("rm_req_seen", bus.mem_req, 1);
    reset = 1'b1;
    tick();
    chk("rm_req", bus.mem_req, 0);
    chk("rm_state", 32'(dut.state), 32'(S_IDLE));
    chk("rm_ready", prog_ready, 0);
    chk("rm_rf", dut.rf[4], 8'd0);
    chk("rm_wptr", dut.wptr, 0);
    reset = 1'b0;
    tick();
    chk("rm_ready_back", prog_ready, 1);

    // Abort in EXEC of the store
    load_prog();
    repeat (22) tick();
    chk("ab_in_exec", 32'(dut.state), 32'(S_EXEC));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_req", bus.mem_req, 0);
    chk("ab_state", 32'(dut.state), 32'(S_IDLE));
    chk("ab_busy", busy, 0);
    chk("ab_ready", prog_ready, 1);
    seen = 1'b0;
    repeat (6) begin tick(); if (done) seen = 1'b1; end
    chk("ab_no_done", seen, 0);

    // Abort coinciding with the load ack
    load_prog();
    wait_req(100, cyc);
    serve(0, 8'h00, held);
    wait_req(100, cyc);
    chk("aa_ld_req", bus.mem_req, 1);
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h5A; abort = 1'b1;
    tick();
    bus.mem_ack = 1'b0; abort = 1'b0;
    chk("aa_req", bus.mem_req, 0);
    chk("aa_state", 32'(dut.state), 32'(S_IDLE));
    chk("aa_rf", dut.rf[5], 8'd0);
    seen = 1'b0;
    repeat (6) begin tick(); if (done) seen = 1'b1; end
    chk("aa_no_done", seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
